// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, owner encoding,
// default widths and the hold-counter saturating increment.
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 10;
    localparam int HOLD_W     = 4;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } owner_e;

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt,
                                                   input logic [HOLD_W-1:0] max);
        return (cnt >= max) ? max : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_rr_sched.sv
// Bounded-hold round-robin scheduler with lock: owns the owner/hold_cnt/last_gnt
// state and produces the combinational grant for the current cycle.
module dmem_rr_sched
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output owner_e            owner,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    owner_e            r_owner;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_last_gnt;

    logic              w_gnt0;
    logic              w_gnt1;
    owner_e            w_owner_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_last_nxt;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            if (req0 && !req1) begin
                w_gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                // Lock keeps the owner; otherwise it yields once it has used MAX_HOLD grants.
                case (r_owner)
                    OWN0: begin
                        if (lock0 || (r_hold_cnt < MAX_HOLD_C)) w_gnt0 = 1'b1;
                        else                                    w_gnt1 = 1'b1;
                    end
                    OWN1: begin
                        if (lock1 || (r_hold_cnt < MAX_HOLD_C)) w_gnt1 = 1'b1;
                        else                                    w_gnt0 = 1'b1;
                    end
                    default: begin
                        if (r_last_gnt) w_gnt0 = 1'b1;
                        else            w_gnt1 = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_owner_nxt = IDLE;
        w_hold_nxt  = '0;
        w_last_nxt  = r_last_gnt;
        if (w_gnt0) begin
            w_owner_nxt = OWN0;
            w_hold_nxt  = (r_owner == OWN0) ? hold_inc(r_hold_cnt, MAX_HOLD_C) : HOLD_W'(1);
            w_last_nxt  = 1'b0;
        end else if (w_gnt1) begin
            w_owner_nxt = OWN1;
            w_hold_nxt  = (r_owner == OWN1) ? hold_inc(r_hold_cnt, MAX_HOLD_C) : HOLD_W'(1);
            w_last_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner    <= IDLE;
            r_hold_cnt <= '0;
            r_last_gnt <= 1'b1;
        end else begin
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last_gnt <= w_last_nxt;
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign owner    = r_owner;
    assign hold_cnt = r_hold_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data-memory port: CPU on port 0, loader on port 1.
// reqX/gntX: the access happens in the cycle gntX is high; a stalled requester holds its request stable.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              stall0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              stall1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_owner,
    output logic [HOLD_W-1:0] dbg_hold_cnt
);

    logic              w_gnt0;
    logic              w_gnt1;
    owner_e            w_owner;
    logic [HOLD_W-1:0] w_hold_cnt;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    dmem_rr_sched #(
        .MAX_HOLD (MAX_HOLD)
    ) u_sched (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .lock0    (lock0),
        .lock1    (lock1),
        .gnt0     (w_gnt0),
        .gnt1     (w_gnt1),
        .owner    (w_owner),
        .hold_cnt (w_hold_cnt)
    );

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_gnt0) begin
            ram_we    = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (w_gnt1) begin
            ram_we    = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
            if (w_gnt0 && !we0) r_rdata0 <= ram_rdata;
            if (w_gnt1 && !we1) r_rdata1 <= ram_rdata;
        end
    end

    // A read return pending when reset arrives is suppressed in that same cycle.
    assign rvalid0 = r_rvalid0 & rst;
    assign rvalid1 = r_rvalid1 & rst;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;
    assign stall0 = rst & req0 & ~w_gnt0;
    assign stall1 = rst & req1 & ~w_gnt1;

    assign dbg_owner    = w_owner;
    assign dbg_hold_cnt = w_hold_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle-by-cycle vector table plus a short
// hand-written sequence for a request dropped while stalled.
module tb_dmem_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [9:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, stall0, rvalid0, gnt1, stall1, rvalid1;
    logic [9:0] rdata0, rdata1;
    logic       ram_we;
    logic [9:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0] dbg_owner;
    logic [3:0] dbg_hold_cnt;

    logic [9:0] mem [0:1023];

    int n_chk;
    int n_err;
    int step;

    typedef struct {
        logic       rst;
        logic       req0, we0, lock0;
        logic [9:0] addr0, wdata0;
        logic       req1, we1, lock1;
        logic [9:0] addr1, wdata1;
        logic       g0, g1, s0, s1, rwe;
        logic [9:0] raddr;
        logic       v0, v1;
        logic [9:0] d0, d1;
        logic [1:0] own;
    } vec_t;

    vec_t vecs[$];

    dmem_arbiter #(
        .ADDR_W   (10),
        .DATA_W   (10),
        .MAX_HOLD (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .we0          (we0),
        .lock0        (lock0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .gnt0         (gnt0),
        .stall0       (stall0),
        .rvalid0      (rvalid0),
        .rdata0       (rdata0),
        .req1         (req1),
        .we1          (we1),
        .lock1        (lock1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .gnt1         (gnt1),
        .stall1       (stall1),
        .rvalid1      (rvalid1),
        .rdata1       (rdata1),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .dbg_owner    (dbg_owner),
        .dbg_hold_cnt (dbg_hold_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: async read, write at the rising edge
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic q0, input logic w0, input logic l0,
                       input logic [9:0] a0, input logic [9:0] d0,
                       input logic q1, input logic w1, input logic l1,
                       input logic [9:0] a1, input logic [9:0] d1,
                       input logic g0, input logic g1, input logic s0, input logic s1,
                       input logic rwe, input logic [9:0] raddr,
                       input logic v0, input logic v1,
                       input logic [9:0] rd0, input logic [9:0] rd1, input logic [1:0] own);
        vec_t v;
        v.rst = r;   v.req0 = q0; v.we0 = w0; v.lock0 = l0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = q1; v.we1 = w1; v.lock1 = l1; v.addr1 = a1; v.wdata1 = d1;
        v.g0 = g0;   v.g1 = g1;   v.s0 = s0;  v.s1 = s1;    v.rwe = rwe;  v.raddr = raddr;
        v.v0 = v0;   v.v1 = v1;   v.d0 = rd0; v.d1 = rd1;   v.own = own;
        vecs.push_back(v);
    endtask

    // driver
    task automatic drive(input vec_t v);
        rst = v.rst;
        req0 = v.req0; we0 = v.we0; lock0 = v.lock0; addr0 = v.addr0; wdata0 = v.wdata0;
        req1 = v.req1; we1 = v.we1; lock1 = v.lock1; addr1 = v.addr1; wdata1 = v.wdata1;
    endtask

    task automatic check_vec(input vec_t v);
        chk("gnt0",     32'(gnt0),      32'(v.g0));
        chk("gnt1",     32'(gnt1),      32'(v.g1));
        chk("stall0",   32'(stall0),    32'(v.s0));
        chk("stall1",   32'(stall1),    32'(v.s1));
        chk("ram_we",   32'(ram_we),    32'(v.rwe));
        chk("ram_addr", 32'(ram_addr),  32'(v.raddr));
        chk("rvalid0",  32'(rvalid0),   32'(v.v0));
        chk("rvalid1",  32'(rvalid1),   32'(v.v1));
        chk("rdata0",   32'(rdata0),    32'(v.d0));
        chk("rdata1",   32'(rdata1),    32'(v.d1));
        chk("owner",    32'(dbg_owner), 32'(v.own));
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        step  = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h005] = 10'h2A3;
        mem[10'h010] = 10'h111;
        mem[10'h020] = 10'h222;

        // rst  q0 w0 l0 a0     d0      q1 w1 l1 a1     d1     | g0 g1 s0 s1 we addr    v0 v1 rd0     rd1     own
        // reset held with both requesting
        add(0, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 0,0,0,0,0,10'h000, 0,0,10'h000,10'h000,2'd0);
        add(0, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 0,0,0,0,0,10'h000, 0,0,10'h000,10'h000,2'd0);
        // contention, MAX_HOLD=4: 0,0,0,0,1,1,1,1,0
        add(1, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 1,0,0,1,0,10'h010, 0,0,10'h000,10'h000,2'd0);
        for (int i = 0; i < 3; i++)
            add(1, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 1,0,0,1,0,10'h010, 1,0,10'h111,10'h000,2'd1);
        add(1, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 0,1,1,0,0,10'h020, 1,0,10'h111,10'h000,2'd1);
        for (int i = 0; i < 3; i++)
            add(1, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 0,1,1,0,0,10'h020, 0,1,10'h111,10'h222,2'd2);
        add(1, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 1,0,0,1,0,10'h010, 0,1,10'h111,10'h222,2'd2);
        // port 1 takes ownership alone, then holds it with lock for 10 contended cycles
        add(1, 0,0,0,10'h010,10'h000, 1,0,1,10'h020,10'h000, 0,1,0,0,0,10'h020, 1,0,10'h111,10'h222,2'd1);
        for (int i = 0; i < 10; i++)
            add(1, 1,0,0,10'h010,10'h000, 1,0,1,10'h020,10'h000, 0,1,1,0,0,10'h020, 0,1,10'h111,10'h222,2'd2);
        // lock dropped with hold_cnt saturated: port 0 wins at once
        add(1, 1,0,0,10'h010,10'h000, 1,0,0,10'h020,10'h000, 1,0,0,1,0,10'h010, 0,1,10'h111,10'h222,2'd2);
        // port 1 writes 0x1FF to 0x3C0, port 0 reads it back
        add(1, 0,0,0,10'h000,10'h000, 1,1,0,10'h3C0,10'h1FF, 0,1,0,0,1,10'h3C0, 1,0,10'h111,10'h222,2'd1);
        add(1, 1,0,0,10'h3C0,10'h000, 0,0,0,10'h000,10'h000, 1,0,0,0,0,10'h3C0, 0,0,10'h111,10'h222,2'd2);
        add(1, 0,0,0,10'h000,10'h000, 0,0,0,10'h000,10'h000, 0,0,0,0,0,10'h000, 1,0,10'h1FF,10'h222,2'd1);
        // single read of 0x005
        add(1, 1,0,0,10'h005,10'h000, 0,0,0,10'h000,10'h000, 1,0,0,0,0,10'h005, 0,0,10'h1FF,10'h222,2'd0);
        add(1, 0,0,0,10'h000,10'h000, 0,0,0,10'h000,10'h000, 0,0,0,0,0,10'h000, 1,0,10'h2A3,10'h222,2'd1);
        // reset in the cycle after a granted read, with a port-1 write pending
        add(1, 1,0,0,10'h010,10'h000, 0,0,0,10'h000,10'h000, 1,0,0,0,0,10'h010, 0,0,10'h2A3,10'h222,2'd0);
        add(0, 0,0,0,10'h000,10'h000, 1,1,0,10'h3C0,10'h0AA, 0,0,0,0,0,10'h000, 0,0,10'h111,10'h222,2'd1);
        add(1, 1,0,0,10'h3C0,10'h000, 0,0,0,10'h000,10'h000, 1,0,0,0,0,10'h3C0, 0,0,10'h000,10'h000,2'd0);
        add(1, 0,0,0,10'h000,10'h000, 0,0,0,10'h000,10'h000, 0,0,0,0,0,10'h000, 1,0,10'h1FF,10'h000,2'd1);

        rst = 1'b0;
        idle_inputs();
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            step = i;
            drive(vecs[i]);
            #1;
            check_vec(vecs[i]);
        end

        // Hand sequence: owner IDLE, last grant port 0 -> tie goes to port 1.
        // Port 0's stalled write to 0x005 is dropped and must never reach RAM.
        @(negedge clk);
        step = 100;
        idle_inputs();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h005; wdata0 = 10'h000;
        req1 = 1'b1; addr1 = 10'h005;
        #1;
        chk("tie_gnt1",   32'(gnt1),     32'd1);
        chk("tie_stall0", 32'(stall0),   32'd1);
        chk("tie_ram_we", 32'(ram_we),   32'd0);
        chk("tie_addr",   32'(ram_addr), 32'h005);

        @(negedge clk);
        step = 101;
        idle_inputs();
        #1;
        chk("drop_gnt0",   32'(gnt0),      32'd0);
        chk("drop_ram_we", 32'(ram_we),    32'd0);
        chk("drop_rvalid1",32'(rvalid1),   32'd1);
        chk("drop_rdata1", 32'(rdata1),    32'h2A3);
        chk("drop_owner",  32'(dbg_owner), 32'd2);

        @(negedge clk);
        step = 102;
        req0 = 1'b1; addr0 = 10'h005;
        #1;
        chk("rb_gnt0",  32'(gnt0),      32'd1);
        chk("rb_owner", 32'(dbg_owner), 32'd0);

        @(negedge clk);
        step = 103;
        idle_inputs();
        #1;
        chk("rb_rvalid0", 32'(rvalid0), 32'd1);
        chk("rb_rdata0",  32'(rdata0),  32'h2A3);
        chk("rb_hold",    32'(dbg_hold_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (async read, sync write, 10-bit address/data) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the loader/debug master.
- Sits between the CPU core, the loader and the RAM instance.
- Provides per-port grant, a CPU stall indication, and registered read-data return, with bounded-hold round-robin fairness and an optional lock.

Parameters:
ADDR_W, 10, address width of RAM and both ports
DATA_W, 10, data width of RAM and both ports
MAX_HOLD, 4, max consecutive grants to one port while the other requests (lock excepted); legal 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low
req0  in  1  port 0 (CPU) access request
we0  in  1  port 0 write enable (0 = read)
lock0  in  1  port 0 hold-grant request, honoured only while req0=1
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 granted this cycle
stall0  out  1  req0 & ~gnt0
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_W  port 0 read data
req1, we1, lock1, addr1, wdata1, gnt1, stall1, rvalid1, rdata1: same as port 0, for port 1
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM async read data

Behaviour:
- State registers:
  - owner: IDLE / OWN0 / OWN1 = port granted in the previous cycle.
  - hold_cnt: 4 bits, consecutive grants to owner, saturating at MAX_HOLD.
  - last_gnt: 1 bit, port most recently granted.
- Reset (rst=0 at an edge): owner=IDLE, hold_cnt=0, last_gnt=1 (port 0 wins first tie), rvalid0/1=0, rdata0/1=0.
- While rst=0: gnt0/1=0, stall0/1=0, ram_we=0.
- Grant is combinational from the current req/lock and registered state. At most one of gnt0/gnt1 is high.
- Grant decision each cycle:
  - No req: no grant; next owner=IDLE, hold_cnt=0.
  - Only reqX: gntX=1.
  - Both req, owner=IDLE: grant ~last_gnt.
  - Both req, owner=OWNX, lockX=1: grant X regardless of hold_cnt.
  - Both req, owner=OWNX, lockX=0, hold_cnt<MAX_HOLD: grant X.
  - Both req, owner=OWNX, lockX=0, hold_cnt=MAX_HOLD: grant the other port.
- Counter update on a grant to port G:
  - If G == owner: hold_cnt = min(hold_cnt+1, MAX_HOLD).
  - Else: hold_cnt=1.
  - owner=OWNG, last_gnt=G.
- RAM mux:
  - Granted port drives ram_addr/ram_wdata; ram_we = weG.
  - No grant: ram_addr=0, ram_wdata=0, ram_we=0.
- Write latency: the write commits at the edge ending the grant cycle.
- Read latency 1:
  - A granted read (weX=0) captures ram_rdata into rdataX at the edge ending the grant cycle; rvalidX=1 for exactly the following cycle.
  - rvalidX=0 after a write grant or a non-granted cycle.
  - rdataX holds its last value when rvalidX=0.
- Requester contract: hold req/we/addr/wdata stable while stalled. The arbiter does not latch requests.
- Request dropped while stalled: no access occurs and no state changes for that port.
- Lock with req low is ignored. A locked owner can starve the other port indefinitely; this is intended for loader bursts.
- Reset mid-operation: a pending rvalid is cleared and no RAM write occurs in the reset cycle.

Decomposition:
- Shared package: port index constants (PORT_CPU=0, PORT_LDR=1), owner state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10), default widths (10).
- Natural sub-module: dmem_rr_sched (owner/hold_cnt/last_gnt state and the grant decision).
- Muxing and read-return registers stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, ram_we=0, rvalid0/1=0; first cycle after release grants port 0.
- Single read: RAM[0x005]=0x2A3, req0=1, we0=0, addr0=0x005 for one cycle -> gnt0=1, ram_addr=0x005; next cycle rvalid0=1, rdata0=0x2A3, rvalid1=0.
- Contention fairness (MAX_HOLD=4): req0=req1=1 continuously, no lock, all reads -> grant sequence 0,0,0,0,1,1,1,1,0,...; stall1=1 during port-0 grants; rvalid follows each grant by one cycle.
- Lock: port 1 owns with lock1=1, req0=1, for 10 cycles -> gnt1 for all 10; drop lock1 -> after port 1's hold_cnt is already at MAX_HOLD, port 0 is granted the next cycle.
- Write then read-back: port 1 writes 0x1FF to 0x3C0, then port 0 reads 0x3C0 -> ram_we=1 only in the write grant cycle; rdata0=0x1FF with rvalid0 one cycle after the read grant.
- Reset mid-operation: assert rst=0 in the cycle after a granted read -> rvalid0=0 that cycle and after; owner=IDLE; no RAM write occurs even with we1=1.
